// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one operand bit per cycle, fixed 33-cycle latency,
// result presented with a one-cycle register-file write enable.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result,
  output logic [4:0]  WA3,
  output logic        WE3
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [31:0] r_srca;
  logic [31:0] r_srcb;
  logic        r_sa;
  logic        r_sb;
  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;
  logic [4:0]  r_wa3;

  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_sum;
  logic [31:0] w_hi_nx;
  logic [31:0] w_lo_nx;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quot_nx;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic        w_div0;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_result;
  logic        w_last;

  // Operand signedness and magnitudes, evaluated on the live inputs for the start cycle.
  always_comb begin
    w_a_signed = (funct3 == F_MUL) || (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                 (funct3 == F_DIV) || (funct3 == F_REM);
    w_b_signed = (funct3 == F_MUL) || (funct3 == F_MULH) ||
                 (funct3 == F_DIV) || (funct3 == F_REM);
    w_sa       = SrcA[31] & w_a_signed;
    w_sb       = SrcB[31] & w_b_signed;
    w_mag_a    = w_sa ? (32'd0 - SrcA) : SrcA;
    w_mag_b    = w_sb ? (32'd0 - SrcB) : SrcB;
  end

  // One shift-add step of the multiplier and one restoring step of the divider.
  always_comb begin
    w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_a} : 33'd0);
    w_hi_nx   = w_sum[32:1];
    w_lo_nx   = {w_sum[0], r_lo[31:1]};
    w_shift   = {r_rem, r_quot[31]};
    w_ge      = (w_shift >= {1'b0, r_mag_b});
    w_diff    = w_shift[31:0] - r_mag_b;
    w_rem_nx  = w_ge ? w_diff : w_shift[31:0];
    w_quot_nx = {r_quot[30:0], w_ge};
  end

  // Sign correction on the final step; a zero divisor overrides the magnitude result.
  always_comb begin
    w_prod     = {w_hi_nx, w_lo_nx};
    w_prod_fix = (r_sa ^ r_sb) ? (64'd0 - w_prod) : w_prod;
    w_div0     = (r_srcb == 32'd0);
    if (w_div0) begin
      w_quot_fix = 32'hFFFF_FFFF;
      w_rem_fix  = r_srca;
    end else begin
      w_quot_fix = (r_sa ^ r_sb) ? (32'd0 - w_quot_nx) : w_quot_nx;
      w_rem_fix  = r_sa ? (32'd0 - w_rem_nx) : w_rem_nx;
    end
  end

  // Result select by operation.
  always_comb begin
    w_result = 32'd0;
    case (r_funct3)
      F_MUL:    w_result = w_prod_fix[31:0];
      F_MULH,
      F_MULHSU,
      F_MULHU:  w_result = w_prod_fix[63:32];
      F_DIV,
      F_DIVU:   w_result = w_quot_fix;
      F_REM,
      F_REMU:   w_result = w_rem_fix;
      default:  w_result = 32'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_last       = (r_cnt == 6'd31);
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_CALC;
        else       w_next_state = S_IDLE;
      end
      S_CALC: begin
        if (w_last) w_next_state = S_DONE;
        else        w_next_state = S_CALC;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Datapath and registered outputs; Result is formed on the last CALC edge so it is valid in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= 6'd0;
      r_funct3 <= 3'd0;
      r_rd     <= 5'd0;
      r_srca   <= 32'd0;
      r_srcb   <= 32'd0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_mag_a  <= 32'd0;
      r_mag_b  <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_rem    <= 32'd0;
      r_quot   <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
      r_wa3    <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_funct3 <= funct3;
            r_rd     <= rd;
            r_srca   <= SrcA;
            r_srcb   <= SrcB;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_hi     <= 32'd0;
            r_lo     <= w_mag_b;
            r_rem    <= 32'd0;
            r_quot   <= w_mag_a;
            r_cnt    <= 6'd0;
            r_busy   <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_CALC: begin
          r_hi   <= w_hi_nx;
          r_lo   <= w_lo_nx;
          r_rem  <= w_rem_nx;
          r_quot <= w_quot_nx;
          r_cnt  <= r_cnt + 6'd1;
          if (w_last) begin
            r_done   <= 1'b1;
            r_result <= w_result;
            r_wa3    <= r_rd;
          end else begin
            r_done <= 1'b0;
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign WE3    = r_done;
  assign Result = r_result;
  assign WA3    = r_wa3;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M vectors, latency, abort and handshake checks.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic [4:0]  WA3;
  logic        WE3;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_issued = 0;
  int          n_done   = 0;
  int          cyc      = 0;
  logic [31:0] last_res = 32'd0;

  mul_div_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .rd     (rd),
    .busy   (busy),
    .done   (done),
    .Result (Result),
    .WA3    (WA3),
    .WE3    (WE3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d required no pending op", cyc);
      end else begin
        e = sb_q.pop_front();
        check("result",  Result, e.res);
        check("wa3",     {27'd0, WA3}, {27'd0, e.rd});
        check("we3",     {31'd0, WE3}, 32'd1);
        check("busy_in_done", {31'd0, busy}, 32'd1);
        check("latency", 32'(cyc - e.cyc), 32'd33);
      end
    end
  end

  // Issue one op in the current cycle, optionally pulse start in cycles 5 and 20; returns in cycle 34.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp_res, input bit pulse);
    exp_t e;
    e.res = exp_res;
    e.rd  = r;
    e.cyc = cyc;
    sb_q.push_back(e);
    n_issued++;
    last_res = exp_res;
    funct3 = f;
    SrcA   = a;
    SrcB   = b;
    rd     = r;
    start  = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk);
      #1;
      start  = pulse && (i == 5 || i == 20);
      SrcA   = $urandom;
      SrcB   = $urandom;
      funct3 = 3'($urandom_range(7, 0));
      rd     = 5'($urandom_range(31, 0));
    end
    check("busy_cycle34", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = 3'd0;
    SrcA   = 32'd0;
    SrcB   = 32'd0;
    rd     = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", Result, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_we3",    {31'd0, WE3},  32'd0);
    check("rst_wa3",    {27'd0, WA3},  32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Abort a DIV with reset held in cycle 10.
    funct3 = 3'b100;
    SrcA   = 32'd1000;
    SrcB   = 32'd3;
    rd     = 5'd9;
    start  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("abort_busy_c10", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_result", Result, 32'd0);

    // Directed vectors, back to back.
    run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0);
    run_op(3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b0);
    run_op(3'b011, 32'h8000_0000, 32'd2,         5'd11, 32'd1,         1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFD, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b101, 32'd100,       32'd7,         5'd14, 32'd14,        1'b0);
    run_op(3'b111, 32'd100,       32'd7,         5'd15, 32'd2,         1'b0);
    run_op(3'b100, 32'hFFFF_FF9C, 32'd7,         5'd16, 32'hFFFF_FFF2, 1'b0);
    run_op(3'b110, 32'hFFFF_FF9C, 32'd7,         5'd17, 32'hFFFF_FFFE, 1'b0);
    run_op(3'b100, 32'd100,       32'hFFFF_FFF9, 5'd18, 32'hFFFF_FFF2, 1'b0);
    run_op(3'b110, 32'd100,       32'hFFFF_FFF9, 5'd19, 32'd2,         1'b0);
    run_op(3'b100, 32'd5,         32'd0,         5'd20, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b111, 32'd13,        32'd0,         5'd21, 32'd13,        1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd0,         5'd22, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd0,         5'd23, 32'hFFFF_FFF9, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 32'h8000_0000, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 32'd0,         1'b0);
    run_op(3'b101, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'hFFFF_FFFF, 1'b0);
    // Stray start pulses mid-op, followed immediately by a cycle-34 start.
    run_op(3'b000, 32'd6,         32'd9,         5'd26, 32'd54,        1'b1);
    run_op(3'b101, 32'd81,        32'd9,         5'd27, 32'd9,         1'b0);

    repeat (10) @(posedge clk);
    #1;
    check("queue_drained", 32'(sb_q.size()), 32'd0);
    check("done_count",    32'(n_done), 32'(n_issued));
    check("result_hold",   Result, last_res);
    check("idle_busy",     {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit sitting beside the ALU in the execute stage, directly between the register file read ports and its write-back port. It consumes the two source operands read from the register file, computes one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU result over a fixed 33-cycle sequence, and presents the 32-bit result with the destination register index and a one-cycle write-enable for the register file write port. While it is busy, the control unit stalls the PC.

## Interface
- No parameters; data width fixed at 32, register index width fixed at 5.
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  32  rs1 value (RD1 of register file)
- SrcB  in  32  rs2 value (RD2 of register file)
- rd  in  5  destination register index
- busy  out  1  high from the first CALC cycle through the DONE cycle
- done  out  1  one-cycle pulse when Result is valid
- Result  out  32  result; holds its last value until the next DONE
- WA3  out  5  latched rd, for the register file write address
- WE3  out  1  equal to done; drives the register file write enable

## Operation
- States: IDLE, CALC, DONE.
- **IDLE -> CALC** when start=1.
  - Latch funct3, rd, raw SrcA/SrcB, and operand signs.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats A as signed and B as unsigned. MULHU/DIVU/REMU treat both as unsigned.
  - Load the magnitudes |A| and |B| as 32-bit unsigned values. |0x80000000| = 0x80000000.
  - Clear the 6-bit counter.
- **CALC** runs 32 cycles, one bit per cycle; counter 0..31. Exits to DONE after count 31.
  - Multiply: shift-add into a 64-bit accumulator, LSB of the multiplier first.
  - Divide: restoring division, MSB first, 33-bit partial remainder, 32-bit quotient.
- **DONE** lasts one cycle, then goes to IDLE. It applies sign correction and selects Result:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - Product sign: negate the 64-bit product when the operand signs differ. Unsigned operands count as positive.
  - DIV/DIVU: quotient, negated when sA^sB.
  - REM/REMU: remainder, negated when sA (the dividend sign).
- **Divide-by-zero override** (SrcB=0, all four divide ops): quotient = 0xFFFFFFFF; remainder = original SrcA.
- **Overflow** (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. This falls out of the magnitude path with no special case.
- start is ignored while busy; no queueing.
- SrcA/SrcB/funct3/rd may change freely after the start cycle.

## Timing
- Reset (rst_n=0 at a rising edge):
  - Outputs: state IDLE, busy=0, done=0, WE3=0, Result=0, WA3=0.
  - Internal: counter and accumulators cleared.
  - Reset mid-operation aborts the operation with no done and no WE3 pulse.
- Cycle numbering: start=1 sampled at the edge ending cycle 0.
  - Cycles 1..32: CALC, busy=1.
  - Cycle 33: DONE, busy=1, done=1, WE3=1, Result and WA3 valid.
  - Cycle 34: IDLE, busy=0. A new start in cycle 34 is accepted, giving back-to-back throughput of one op per 34 cycles.
- Latency is fixed at 33 cycles for every op, including divide-by-zero and overflow.
- done and WE3 are registered outputs, never combinational from start.
- WA3 = 0 is still written with WE3=1; the register file already masks x0 reads.

## Test plan
- **Reset and idle:** after reset, Result=0, busy=0, done=0. Hold rst_n=0 in cycle 10 of a DIV -> no done pulse; busy=0 on the next cycle.
- **MUL and latency:** MUL 7 x 0xFFFFFFFD -> Result 0xFFFFFFEB in cycle 33, WA3=rd, one-cycle WE3. MULH 0x80000000 x 0x80000000 -> 0x40000000.
- **Unsigned and mixed-sign high product:** MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- **Signed divide:** DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 % 7 -> 2.
- **Corner cases:** DIV 5 / 0 -> 0xFFFFFFFF. REMU 13 / 0 -> 13. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. All complete in cycle 33.
- **Handshake:** start pulsed in cycles 5 and 20 of an op -> both ignored, one done only. A new start in cycle 34 -> second done in cycle 67.
